// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg7_pkg;

  localparam int NIB_W          = 4;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DWELL_W    = 8;
  localparam int MAX_DIGITS     = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Callers truncate the result to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/seg7_digit_bank.sv
// Shadow/active digit store with commit transfer and leading-zero blank vector.
// Writes take effect next edge; active_nxt/blank_nxt show the post-transfer view a cycle early.
module seg7_digit_bank
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int IW         = $clog2(NUM_DIGITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [IW-1:0]               wr_addr,
  input  logic [NIB_W-1:0]            wr_data,
  input  logic                        xfer,
  input  logic                        lzb_en,
  output logic [NUM_DIGITS*NIB_W-1:0] active_nxt,
  output logic [NUM_DIGITS-1:0]       blank_nxt
);

  logic [NUM_DIGITS*NIB_W-1:0] shadow_q;
  logic [NUM_DIGITS*NIB_W-1:0] active_q;
  logic                        all_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      // Addresses past the last digit are acknowledged but dropped.
      if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
        shadow_q[int'(wr_addr)*NIB_W +: NIB_W] <= wr_data;
      end
      if (xfer) begin
        active_q <= shadow_q;
      end
    end
  end

  // The scanner registers its outputs from the next state, so it needs the
  // bank contents as they will be after this edge's transfer.
  assign active_nxt = xfer ? shadow_q : active_q;

  always_comb begin
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero     = all_zero && (active_nxt[i*NIB_W +: NIB_W] == '0);
      blank_nxt[i] = lzb_en && all_zero;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: SHOW (dwell+1) / GAP per digit, commits land at frame end.
// Outputs registered from next state; wr_ready drops while a commit is pending.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter  int DWELL_W    = DEF_DWELL_W,
  parameter  int GAP_CYCLES = 2,
  localparam int IW         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  lzb_en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IW-1:0]         wr_addr,
  input  logic [NIB_W-1:0]      wr_data,
  input  logic                  commit,
  output logic [NIB_W-1:0]      nib_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);

  localparam int                GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]     GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_DIGITS - 1);

  state_t                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [DWELL_W-1:0]          cnt_q, cnt_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic                        pending_q, pending_d;
  logic [NIB_W-1:0]            nib_q, nib_d;
  logic [NUM_DIGITS-1:0]       dig_en_q, dig_en_d;
  logic                        frame_done_q, frame_done_d;

  logic                        advance;
  logic                        boundary;
  logic                        xfer;
  logic                        wr_en;
  logic [NUM_DIGITS*NIB_W-1:0] active_nxt;
  logic [NUM_DIGITS-1:0]       blank_nxt;

  assign wr_ready   = !pending_q;
  assign wr_en      = wr_valid && !pending_q;
  assign nib_out    = nib_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

  seg7_digit_bank #(
    .NUM_DIGITS (NUM_DIGITS),
    .IW         (IW)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .xfer       (xfer),
    .lzb_en     (lzb_en),
    .active_nxt (active_nxt),
    .blank_nxt  (blank_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      pending_q    <= 1'b0;
      nib_q        <= '0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      pending_q    <= pending_d;
      nib_q        <= nib_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    advance  = 1'b0;
    boundary = 1'b0;

    case (state_q)
      ST_OFF: begin
        state_d = ST_SHOW;
        idx_d   = '0;
        cnt_d   = dwell;
      end
      ST_SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES == 0) begin
          advance = 1'b1;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (advance) begin
      state_d = ST_SHOW;
      cnt_d   = dwell;
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Disable wins everywhere and suppresses the frame end of an aborted scan.
    if (!enable) begin
      state_d  = ST_OFF;
      idx_d    = '0;
      boundary = 1'b0;
    end

    xfer      = pending_q && (boundary || (state_q == ST_OFF));
    pending_d = pending_q;
    if (xfer) begin
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end

    frame_done_d = boundary || (xfer && (state_q == ST_OFF));
    dig_en_d     = '0;
    nib_d        = nib_q;
    case (state_d)
      ST_SHOW: begin
        nib_d = active_nxt[int'(idx_d)*NIB_W +: NIB_W];
        if (!blank_nxt[idx_d]) begin
          dig_en_d = NUM_DIGITS'(onehot(3'(idx_d)));
        end
      end
      ST_GAP:  nib_d = nib_q;
      default: nib_d = '0;
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: output stream compressed into (dig_en, nib, length) runs and frame_done intervals.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] dwell = 8'd3;
  logic       lzb_en = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       commit = 1'b0;
  logic [3:0] nib_out;
  logic [3:0] dig_en;
  logic       frame_done;

  seg7_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .dwell      (dwell),
    .lzb_en     (lzb_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .nib_out    (nib_out),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       fd;
    logic [3:0] en;
    logic [3:0] nib;
    int       len;
  } tok_t;

  tok_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   tok_no = 0;

  bit         mon_on = 1'b0;
  int         mon_epoch = 0;
  int         seen_epoch = -1;
  int         cyc = 0;
  int         run_len = 0;
  int         last_fd = 0;
  bit         run_first = 1'b0;
  bit         have_fd = 1'b0;
  logic [3:0] cur_en = '0;
  logic [3:0] cur_nib = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic r(input logic [3:0] en, input logic [3:0] nib, input int len);
    tok_t t;
    t.fd = 1'b0; t.en = en; t.nib = nib; t.len = len;
    exp_q.push_back(t);
  endtask

  task automatic f(input int len);
    tok_t t;
    t.fd = 1'b1; t.en = '0; t.nib = '0; t.len = len;
    exp_q.push_back(t);
  endtask

  // Expected len < 0 means the run started before monitoring did.
  task automatic emit(input bit fd, input logic [3:0] en, input logic [3:0] nib, input int len);
    tok_t e;
    checks++;
    tok_no++;
    if (exp_q.size() == 0) begin
      $display("FAIL token %0d unexpected: got %s en=%b nib=%h len=%0d, required nothing",
               tok_no, fd ? "frame_done" : "run", en, nib, len);
      return;
    end
    e = exp_q.pop_front();
    if (e.fd == fd && (fd || (e.en === en && e.nib === nib)) && (e.len < 0 || e.len == len))
      passes++;
    else
      $display("FAIL token %0d: got %s en=%b nib=%h len=%0d, required %s en=%b nib=%h len=%0d",
               tok_no, fd ? "frame_done" : "run", en, nib, len,
               e.fd ? "frame_done" : "run", e.en, e.nib, e.len);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (seen_epoch != mon_epoch) begin
        seen_epoch = mon_epoch;
        cur_en     = dig_en;
        cur_nib    = nib_out;
        run_len    = 1;
        run_first  = 1'b1;
        have_fd    = 1'b0;
      end else if (dig_en !== cur_en || nib_out !== cur_nib) begin
        emit(1'b0, cur_en, cur_nib, run_first ? -1 : run_len);
        cur_en    = dig_en;
        cur_nib   = nib_out;
        run_len   = 1;
        run_first = 1'b0;
      end else begin
        run_len++;
      end
      if (frame_done === 1'b1) begin
        emit(1'b1, '0, '0, have_fd ? cyc - last_fd : -1);
        have_fd = 1'b1;
        last_fd = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_cyc(input int a, input int d, input bit c);
    wr_valid = 1'b1;
    wr_addr  = 2'(a);
    wr_data  = 4'(d);
    commit   = c;
    tick(1);
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic wait_empty(input string phase);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 300);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL %s timeout: %0d tokens still pending, required 0", phase, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while held in reset.
    #12;
    check("rst_dig_en", dig_en, 0);
    check("rst_nib", nib_out, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // Load {9,4,7,1} with the commit on the last write; lands while off.
    f(-1);
    mon_epoch++; mon_on = 1'b1;
    wr_cyc(0, 1, 0);
    wr_cyc(1, 7, 0);
    wr_cyc(2, 4, 0);
    wr_cyc(3, 9, 1);
    check("ready_while_pending", wr_ready, 0);
    wait_empty("commit_off");
    check("ready_after_land", wr_ready, 1);

    // Two full frames, dwell 3, gap 2.
    r(4'h0, 4'h0, -1);
    repeat (2) begin
      r(4'h1, 4'h1, 4); r(4'h0, 4'h1, 2); r(4'h2, 4'h7, 4); r(4'h0, 4'h7, 2);
      r(4'h4, 4'h4, 4); r(4'h0, 4'h4, 2); r(4'h8, 4'h9, 4); r(4'h0, 4'h9, 2);
    end
    f(-1);
    exp_q.insert(9, '{fd: 1'b1, en: 4'h0, nib: 4'h0, len: -1});
    void'(exp_q.pop_back());
    f(24);
    mon_epoch++;
    enable = 1'b1;
    wait_empty("scan");

    // Same-cycle write+commit, then a blocked write while pending.
    r(4'h1, 4'h1, -1); r(4'h0, 4'h1, 2); r(4'h2, 4'h7, 4); r(4'h0, 4'h7, 2);
    r(4'h4, 4'h4, 4); r(4'h0, 4'h4, 2); r(4'h8, 4'h9, 4); r(4'h0, 4'h9, 2); f(-1);
    r(4'h1, 4'h1, 4); r(4'h0, 4'h1, 2); r(4'h2, 4'h7, 4); r(4'h0, 4'h7, 2);
    r(4'h4, 4'h5, 4); r(4'h0, 4'h5, 2); r(4'h8, 4'h9, 4); r(4'h0, 4'h9, 2); f(24);
    mon_epoch++;
    wr_cyc(2, 5, 1);
    check("ready_pending_scan", wr_ready, 0);
    wr_cyc(0, 15, 0);
    check("ready_still_pending", wr_ready, 0);
    wait_empty("pending_commit");
    check("ready_after_boundary", wr_ready, 1);

    // Leading-zero blanking with active {0,0,3,0}.
    r(4'h1, 4'h1, -1); r(4'h0, 4'h1, 2); r(4'h2, 4'h7, 4); r(4'h0, 4'h7, 2);
    r(4'h4, 4'h5, 4); r(4'h0, 4'h5, 2); r(4'h8, 4'h9, 4); r(4'h0, 4'h9, 2); f(-1);
    r(4'h1, 4'h0, 4); r(4'h0, 4'h0, 2); r(4'h2, 4'h3, 4); r(4'h0, 4'h3, 2);
    r(4'h0, 4'h0, 12); f(24);
    mon_epoch++;
    lzb_en = 1'b1;
    wr_cyc(0, 0, 0);
    wr_cyc(1, 3, 0);
    wr_cyc(2, 0, 0);
    wr_cyc(3, 0, 1);
    wait_empty("lzb");

    // Disable in digit 2's gap, commit while off, re-enable.
    r(4'h1, 4'h0, -1); r(4'h0, 4'h0, 2); r(4'h2, 4'h3, 4); r(4'h0, 4'h3, 2);
    r(4'h4, 4'h0, 4); r(4'h0, 4'h0, 2); r(4'h8, 4'h0, 4); r(4'h0, 4'h0, 2); f(-1);
    r(4'h1, 4'h0, 4); r(4'h0, 4'h0, 2); r(4'h2, 4'h3, 4); r(4'h0, 4'h3, 2);
    r(4'h4, 4'h6, 4); r(4'h0, 4'h6, 1); f(21); r(4'h0, 4'h0, 6);
    r(4'h1, 4'h0, 4); r(4'h0, 4'h0, 2); r(4'h2, 4'h3, 4); r(4'h0, 4'h3, 2);
    r(4'h4, 4'h6, 4); r(4'h0, 4'h6, 2); r(4'h8, 4'h8, 4); r(4'h0, 4'h8, 2); f(26);
    mon_epoch++;
    lzb_en = 1'b0;
    wr_cyc(2, 6, 1);
    tick(38);
    enable = 1'b0;
    tick(3);
    wr_cyc(3, 8, 1);
    tick(2);
    enable = 1'b1;
    wait_empty("abort_restart");

    // Asynchronous reset in the middle of digit 0's SHOW.
    check("pre_reset_dig_en", dig_en, 4'b0001);
    mon_on = 1'b0;
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("async_rst_dig_en", dig_en, 0);
    check("async_rst_nib", nib_out, 0);
    check("async_rst_frame_done", frame_done, 0);
    check("async_rst_wr_ready", wr_ready, 1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    f(-1); r(4'h0, 4'h0, -1);
    r(4'h1, 4'h0, 4); r(4'h0, 4'h0, 2); r(4'h2, 4'h0, 4); r(4'h0, 4'h0, 2);
    r(4'h4, 4'h0, 4); r(4'h0, 4'h0, 2); r(4'h8, 4'h0, 4); r(4'h0, 4'h0, 2); f(25);
    tick(1);
    mon_epoch++; mon_on = 1'b1;
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    tick(1);
    enable = 1'b1;
    wait_empty("post_reset");
    mon_on = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
